if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the MIPS pipeline. It sits directly downstream of the pre-IF stage and directly upstream of decode. It accepts fetch requests from pre-IF, collects the 16-byte aligned instruction group that the inst cache returns, and splits the group into per-instruction entries. These entries go into an 8-entry instruction queue that feeds decode one instruction per cycle. It also tells pre-IF how many bytes the accepted request covered, which drives sequential-PC generation, and it discards responses that a reflush has made stale.

## Interface
Parameters:
- QDEPTH, 8: instruction queue entries; power of two, at least 8.

Ports:
- clk  in  1  sole clock.
- resetn  in  1  asynchronous, active-low reset.
- to_fs_valid  in  1  pre-IF request handshake; a transfer occurs when to_fs_valid & fs_allowin.
- preif_to_fs_bus  in  39  {tlb_refill[38], has_exc[37], exc_type[36:32], pc[31:0]}.
- fs_allowin  out  1  ready to pre-IF.
- inst_offset  out  6  byte advance for the last accepted pc.
- inst_cache_data_ok  in  1  response strobe from the inst cache.
- inst_cache_rdata  in  128  aligned group; word k in bits [32k+31:32k].
- fs_reflush  in  1  exception/eret flush; the same pulse that pre-IF receives.
- ds_allowin  in  1  decode ready.
- fs_to_ds_valid  out  1  queue head valid.
- fs_to_ds_bus  out  71  {tlb_refill[70], has_exc[69], exc_type[68:64], pc[63:32], inst[31:0]}.

## Operation
- FSM states: IDLE, WAIT, DROP.
- fs_allowin = (state==IDLE) & (count <= QDEPTH-4).
- Accept when to_fs_valid & fs_allowin:
  - Register pc and the exception fields.
  - If has_exc: no cache data is expected. Push one entry with inst=0 and the exception fields, and set inst_offset=4. State stays IDLE.
  - Otherwise: go to WAIT and set inst_offset = 16 - pc[3:0], which is one of 16, 12, 8 or 4.
- WAIT with data_ok:
  - Push n = 4 - pc[3:2] entries, words pc[3:2] through 3, in order.
  - Entry j gets pc = {pc[31:4], pc[3:2]+j, 2'b00}, with the exception fields clear.
  - Go to IDLE.
- Reflush (fs_reflush=1):
  - Clear the queue: count=0 and both pointers reset. Any pop or push that cycle is ignored.
  - In WAIT without data_ok: go to DROP.
  - In WAIT with data_ok: discard the data and go to IDLE.
  - In IDLE: an accept in the same cycle is honoured, because the pc is the reflush target. An exception entry from that accept is pushed after the clear.
- DROP with data_ok: discard the data and go to IDLE. fs_allowin stays 0 while in DROP.
- Queue:
  - Circular, with wr_ptr/rd_ptr of log2(QDEPTH) bits wrapping modulo QDEPTH, and count of log2(QDEPTH)+1 bits.
  - Pop when fs_to_ds_valid & ds_allowin.
  - A push and a pop in the same cycle gives count += n-1.
  - The fs_allowin condition guarantees there is room for 4 entries, so the queue never overflows.
  - fs_to_ds_valid = (count != 0).
- Wrong-path words after a taken branch's delay slot are delivered as-is. Decode discards them.

## Timing
- Reset values: state=IDLE, count=0, pointers=0, fs_to_ds_valid=0, fs_allowin=1 once resetn is high, inst_offset=4.
  - inst_offset=4 makes pre-IF's reset pc 0xbfbffffc + 4 = 0xbfc00000.
- Reset taken mid-WAIT loses the outstanding response. The cache is reset together with this stage.
- Accept at the edge ending cycle T; inst_offset is valid from T+1.
- data_ok arrives in cycle T+1 at the earliest. Its entries are written at the end of that cycle and are visible at the queue head from T+2.
- Exception request accepted in cycle T: the entry is visible at the queue head from T+1.
- At most one cache request is outstanding. fs_allowin is 0 from the cycle after an accept until the cycle after data_ok.
- fs_to_ds_bus is read combinationally from the head entry. Its value must hold while fs_to_ds_valid=1 and ds_allowin=0.

## Structure
- Add to mycpu.h: FS_TO_DS_BUS_WD=71 and the exception-field bit offsets (already shared with pre-IF).
- Sub-module inst_queue: parameterised FIFO with a 4-wide, variable-count push (n = 1..4), a 1-wide pop, and a synchronous clear.
- The FSM, group splitting and inst_offset logic stay in if_stage.

## Test plan
- Reset release, accept pc=0xbfc00000, then data_ok with rdata = {W3,W2,W1,W0}:
  - inst_offset is 16.
  - Decode receives W0..W3 with pcs 0xbfc00000, 0xbfc00004, 0xbfc00008, 0xbfc0000c, one per cycle.
- Accept pc=0x8000_0008:
  - inst_offset is 8.
  - Exactly 2 entries: W2 at 0x80000008 and W3 at 0x8000000c.
- Exception request with pc=0x00400002, has_exc=1, exc_type=4:
  - One entry with inst=0 and exc_type=4, visible the next cycle.
  - inst_offset is 4, and no cache wait occurs.
- Reflush in WAIT, with data_ok two cycles later:
  - The queue empties and state goes to DROP.
  - The stale group is never delivered, and fs_allowin rises the cycle after that data_ok.
- ds_allowin held at 0 while 3 groups arrive:
  - fs_allowin drops once count exceeds 4.
  - No overflow occurs.
  - Releasing ds_allowin drains all entries in order.
- Reflush coincident with data_ok in WAIT: the data is discarded, state goes to IDLE, and fs_allowin=1 the next cycle.

Source files
------------

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared definitions for the instruction-fetch stage.
//   - bus widths and pre-IF bus field offsets (shared with pre-IF)
//   - fs_entry_t: one instruction-queue entry, laid out exactly as fs_to_ds_bus
//   - FSM state encodings and small helpers for splitting a 16-byte group
package if_stage_pkg;

  localparam int unsigned PREIF_TO_FS_BUS_WD = 39;
  localparam int unsigned FS_TO_DS_BUS_WD    = 71;

  // Field offsets inside preif_to_fs_bus.
  localparam int unsigned BUS_TLB_REFILL  = 38;
  localparam int unsigned BUS_HAS_EXC     = 37;
  localparam int unsigned BUS_EXC_TYPE_HI = 36;
  localparam int unsigned BUS_EXC_TYPE_LO = 32;

  typedef struct packed {
    logic        tlb_refill;
    logic        has_exc;
    logic [4:0]  exc_type;
    logic [31:0] pc;
    logic [31:0] inst;
  } fs_entry_t;

  localparam logic [1:0] FS_IDLE = 2'd0;
  localparam logic [1:0] FS_WAIT = 2'd1;
  localparam logic [1:0] FS_DROP = 2'd2;

  // pc of word k inside the 16-byte line
  function automatic logic [31:0] group_pc(logic [27:0] line, logic [1:0] k);
    return {line, k, 2'b00};
  endfunction

  // word k of an aligned group; k wraps so unused lanes stay in range
  function automatic logic [31:0] group_word(logic [127:0] grp, logic [1:0] k);
    return grp[{k, 5'd0} +: 32];
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: bundles the fetch-stage handshakes.
//   pre-IF side : to_fs_valid, preif_to_fs_bus, fs_allowin, inst_offset, fs_reflush
//   cache side  : inst_cache_data_ok, inst_cache_rdata
//   decode side : ds_allowin, fs_to_ds_valid, fs_to_ds_bus
// master = surrounding pipeline/cache, slave = if_stage.
interface if_stage_if;
  import if_stage_pkg::*;

  logic                          to_fs_valid;
  logic [PREIF_TO_FS_BUS_WD-1:0] preif_to_fs_bus;
  logic                          fs_allowin;
  logic [5:0]                    inst_offset;
  logic                          inst_cache_data_ok;
  logic [127:0]                  inst_cache_rdata;
  logic                          fs_reflush;
  logic                          ds_allowin;
  logic                          fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0]    fs_to_ds_bus;

  modport master (
    output to_fs_valid, preif_to_fs_bus, inst_cache_data_ok, inst_cache_rdata,
           fs_reflush, ds_allowin,
    input  fs_allowin, inst_offset, fs_to_ds_valid, fs_to_ds_bus
  );

  modport slave (
    input  to_fs_valid, preif_to_fs_bus, inst_cache_data_ok, inst_cache_rdata,
           fs_reflush, ds_allowin,
    output fs_allowin, inst_offset, fs_to_ds_valid, fs_to_ds_bus
  );

endinterface

// File: rtl/if_stage_inst_queue.sv
// if_stage_inst_queue: circular instruction FIFO, 4-wide push of 1..4 entries,
// 1-wide pop, synchronous clear.
//   clk, resetn   : clock, async active-low reset
//   i_clr         : empty the queue; a pop that cycle is ignored, a push lands after the clear
//   i_push/i_push_n/i_push_data : write lanes 0..i_push_n-1 in order
//   i_pop         : remove head entry (ignored when empty)
//   o_valid/o_head/o_count      : head entry (combinational) and occupancy
module if_stage_inst_queue
  import if_stage_pkg::*;
#(
  parameter int unsigned QDEPTH = 8,
  localparam int unsigned PtrW = $clog2(QDEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 i_clr,
  input  logic                 i_push,
  input  logic [2:0]           i_push_n,
  input  fs_entry_t [3:0]      i_push_data,
  input  logic                 i_pop,
  output logic                 o_valid,
  output fs_entry_t            o_head,
  output logic [CntW-1:0]      o_count
);

  fs_entry_t         r_mem [QDEPTH];
  logic [PtrW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]   r_count;

  logic              w_pop;
  logic [PtrW-1:0]   w_wr_base, w_wr_next, w_rd_next;
  logic [CntW-1:0]   w_cnt_base, w_push_cnt, w_count_d;

  assign w_pop      = i_pop & (r_count != '0) & ~i_clr;
  // A clear rebases the pointers first so a same-cycle push lands at slot 0.
  assign w_wr_base  = i_clr ? '0 : r_wr_ptr;
  assign w_cnt_base = i_clr ? '0 : r_count;
  assign w_push_cnt = i_push ? CntW'(i_push_n) : '0;
  assign w_wr_next  = w_wr_base + (i_push ? PtrW'(i_push_n) : '0);
  assign w_rd_next  = i_clr ? '0 : r_rd_ptr + PtrW'(w_pop);
  assign w_count_d  = w_cnt_base + w_push_cnt - CntW'(w_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      if (i_push && (3'(j) < i_push_n)) begin
        r_mem[w_wr_base + PtrW'(j)] <= i_push_data[j];
      end
    end
  end

  assign o_valid = (r_count != '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage.
// Accepts a pc from pre-IF, waits for the 16-byte group from the inst cache,
// splits it from the requested word to the end of the line into the instruction
// queue, and reports the byte advance (inst_offset) back to pre-IF. A reflush
// empties the queue and drops any outstanding response.
//   clk, resetn : clock, async active-low reset
//   io_fs       : if_stage_if.slave (pre-IF, inst cache and decode handshakes)
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned QDEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  if_stage_if.slave   io_fs
);

  localparam int unsigned CntW = $clog2(QDEPTH) + 1;

  logic [1:0]      r_state, w_state_d;
  logic [31:2]     r_pc;
  logic [5:0]      r_inst_offset;

  logic            w_accept, w_has_exc, w_exc_push, w_grp_push, w_push, w_pop;
  logic [2:0]      w_push_n;
  fs_entry_t [3:0] w_group, w_push_data;
  fs_entry_t       w_head;
  logic            w_q_valid;
  logic [CntW-1:0] w_count;

  // Leaving room for a full group means a granted request can never overflow.
  assign io_fs.fs_allowin = (r_state == FS_IDLE) & (w_count <= CntW'(QDEPTH - 4));
  assign w_accept   = io_fs.to_fs_valid & io_fs.fs_allowin;
  assign w_has_exc  = io_fs.preif_to_fs_bus[BUS_HAS_EXC];
  // Exception requests bypass the cache and are queued straight away.
  assign w_exc_push = w_accept & w_has_exc;
  assign w_grp_push = (r_state == FS_WAIT) & io_fs.inst_cache_data_ok & ~io_fs.fs_reflush;
  assign w_push     = w_exc_push | w_grp_push;
  assign w_push_n   = w_exc_push ? 3'd1 : 3'd4 - {1'b0, r_pc[3:2]};
  assign w_pop      = w_q_valid & io_fs.ds_allowin;

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      w_group[j].tlb_refill = 1'b0;
      w_group[j].has_exc    = 1'b0;
      w_group[j].exc_type   = 5'd0;
      w_group[j].pc         = group_pc(r_pc[31:4], r_pc[3:2] + 2'(j));
      w_group[j].inst       = group_word(io_fs.inst_cache_rdata, r_pc[3:2] + 2'(j));
    end
    w_push_data = w_group;
    if (w_exc_push) begin
      // Bus layout matches the entry's upper fields; the instruction is zero.
      w_push_data[0] = {io_fs.preif_to_fs_bus, 32'h0};
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      FS_IDLE: if (w_accept && !w_has_exc) w_state_d = FS_WAIT;
      FS_WAIT: begin
        if (io_fs.inst_cache_data_ok)  w_state_d = FS_IDLE;
        else if (io_fs.fs_reflush)     w_state_d = FS_DROP;
      end
      FS_DROP: if (io_fs.inst_cache_data_ok) w_state_d = FS_IDLE;
      default: w_state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= FS_IDLE;
      r_pc          <= '0;
      // Pre-IF's reset pc plus 4 lands on the boot vector.
      r_inst_offset <= 6'd4;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_pc          <= io_fs.preif_to_fs_bus[31:2];
        r_inst_offset <= w_has_exc ? 6'd4 : 6'd16 - {2'b00, io_fs.preif_to_fs_bus[3:0]};
      end
    end
  end

  if_stage_inst_queue #(
    .QDEPTH (QDEPTH)
  ) u_inst_queue (
    .clk         (clk),
    .resetn      (resetn),
    .i_clr       (io_fs.fs_reflush),
    .i_push      (w_push),
    .i_push_n    (w_push_n),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_valid     (w_q_valid),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign io_fs.inst_offset    = r_inst_offset;
  assign io_fs.fs_to_ds_valid = w_q_valid;
  assign io_fs.fs_to_ds_bus   = w_head;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  if_stage_if u_if ();

  if_stage #(
    .QDEPTH (8)
  ) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .io_fs  (u_if)
  );

  task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = free, 1 = awaiting cache data, 2 = awaiting stale data to discard
  logic [70:0] m_q[$];
  int          m_mode = 0;
  logic [5:0]  m_off  = 6'd4;
  logic [31:0] m_pc   = '0;
  bit          m_acc, m_pop, m_grp;

  initial forever begin
    @(posedge clk);
    if (!resetn) begin
      m_q.delete();
      m_mode = 0;
      m_off  = 6'd4;
    end else begin
      m_acc = u_if.to_fs_valid && (m_mode == 0) && (m_q.size() <= 4);
      m_pop = (m_q.size() != 0) && u_if.ds_allowin;
      m_grp = (m_mode == 1) && u_if.inst_cache_data_ok && !u_if.fs_reflush;
      if (u_if.fs_reflush) m_q.delete();
      else if (m_pop) void'(m_q.pop_front());
      if (m_grp) begin
        for (int k = m_pc[3:2]; k < 4; k++) begin
          m_q.push_back({7'd0, m_pc[31:4], k[1:0], 2'b00, u_if.inst_cache_rdata[32*k +: 32]});
        end
      end
      case (m_mode)
        0: if (m_acc && !u_if.preif_to_fs_bus[37]) m_mode = 1;
        1: if (u_if.inst_cache_data_ok) m_mode = 0; else if (u_if.fs_reflush) m_mode = 2;
        default: if (u_if.inst_cache_data_ok) m_mode = 0;
      endcase
      if (m_acc) begin
        m_pc = u_if.preif_to_fs_bus[31:0];
        if (u_if.preif_to_fs_bus[37]) begin
          m_q.push_back({u_if.preif_to_fs_bus, 32'h0});
          m_off = 6'd4;
        end else begin
          m_off = 6'd16 - {2'b00, u_if.preif_to_fs_bus[3:0]};
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (resetn) begin
      check("fs_to_ds_valid", 71'(u_if.fs_to_ds_valid), 71'(m_q.size() != 0));
      if (m_q.size() != 0) check("fs_to_ds_bus", u_if.fs_to_ds_bus, m_q[0]);
      check("fs_allowin", 71'(u_if.fs_allowin), 71'((m_mode == 0) && (m_q.size() <= 4)));
      check("inst_offset", 71'(u_if.inst_offset), 71'(m_off));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a request until it is granted, bounded.
  task automatic request(input logic [38:0] bus);
    bit done = 0;
    u_if.to_fs_valid     = 1'b1;
    u_if.preif_to_fs_bus = bus;
    for (int i = 0; i < 40 && !done; i++) begin
      if (u_if.fs_allowin) done = 1;
      tick();
    end
    u_if.to_fs_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL request_grant: got no grant expected grant for %h", bus);
    end
  endtask

  task automatic respond(input int lat, input logic [127:0] data);
    repeat (lat) tick();
    u_if.inst_cache_data_ok = 1'b1;
    u_if.inst_cache_rdata   = data;
    tick();
    u_if.inst_cache_data_ok = 1'b0;
  endtask

  localparam logic [127:0] G1 = {32'h2403_0003, 32'h2402_0002, 32'h2401_0001, 32'h3c1d_a000};
  localparam logic [127:0] G2 = {32'haaaa_0003, 32'haaaa_0002, 32'haaaa_0001, 32'haaaa_0000};
  localparam logic [127:0] G3 = {32'hbbbb_0003, 32'hbbbb_0002, 32'hbbbb_0001, 32'hbbbb_0000};
  localparam logic [127:0] GS = {32'hdead_0003, 32'hdead_0002, 32'hdead_0001, 32'hdead_0000};

  initial begin
    u_if.to_fs_valid        = 1'b0;
    u_if.preif_to_fs_bus    = '0;
    u_if.inst_cache_data_ok = 1'b0;
    u_if.inst_cache_rdata   = '0;
    u_if.fs_reflush         = 1'b0;
    u_if.ds_allowin         = 1'b1;

    // Reset values
    tick();
    check("rst_valid", 71'(u_if.fs_to_ds_valid), 71'd0);
    check("rst_offset", 71'(u_if.inst_offset), 71'd4);
    tick();
    resetn = 1'b1;
    tick();
    check("rst_allowin", 71'(u_if.fs_allowin), 71'd1);

    // Aligned group from the boot vector
    request({7'd0, 32'hbfc0_0000});
    check("t1_offset", 71'(u_if.inst_offset), 71'd16);
    check("t1_allowin_wait", 71'(u_if.fs_allowin), 71'd0);
    respond(0, G1);
    check("t1_head0", u_if.fs_to_ds_bus, {7'd0, 32'hbfc0_0000, 32'h3c1d_a000});
    tick();
    check("t1_head1", u_if.fs_to_ds_bus, {7'd0, 32'hbfc0_0004, 32'h2401_0001});
    repeat (4) tick();
    check("t1_drained", 71'(u_if.fs_to_ds_valid), 71'd0);

    // Mid-line pc: two words only
    request({7'd0, 32'h8000_0008});
    check("t2_offset", 71'(u_if.inst_offset), 71'd8);
    respond(1, G2);
    check("t2_head_w2", u_if.fs_to_ds_bus, {7'd0, 32'h8000_0008, 32'haaaa_0002});
    tick();
    check("t2_head_w3", u_if.fs_to_ds_bus, {7'd0, 32'h8000_000c, 32'haaaa_0003});
    tick();
    check("t2_empty", 71'(u_if.fs_to_ds_valid), 71'd0);

    // Exception request: entry next cycle, no cache wait
    request({1'b0, 1'b1, 5'd4, 32'h0040_0002});
    check("t3_valid", 71'(u_if.fs_to_ds_valid), 71'd1);
    check("t3_entry", u_if.fs_to_ds_bus, {1'b0, 1'b1, 5'd4, 32'h0040_0002, 32'h0});
    check("t3_offset", 71'(u_if.inst_offset), 71'd4);
    check("t3_allowin", 71'(u_if.fs_allowin), 71'd1);
    tick();

    // Reflush while waiting; stale data two cycles later
    u_if.ds_allowin = 1'b0;
    request({1'b1, 1'b1, 5'd2, 32'h8000_0180});
    request({7'd0, 32'h8000_1000});
    u_if.fs_reflush = 1'b1;
    tick();
    u_if.fs_reflush = 1'b0;
    check("t4_flushed", 71'(u_if.fs_to_ds_valid), 71'd0);
    check("t4_drop_allowin", 71'(u_if.fs_allowin), 71'd0);
    respond(1, GS);
    check("t4_allowin_back", 71'(u_if.fs_allowin), 71'd1);
    check("t4_no_stale", 71'(u_if.fs_to_ds_valid), 71'd0);
    u_if.ds_allowin = 1'b1;

    // Back-pressure: queue fills, allowin drops, then drains in order
    u_if.ds_allowin = 1'b0;
    request({7'd0, 32'h9000_0000});
    respond(0, G3);
    check("t5_allowin_at4", 71'(u_if.fs_allowin), 71'd1);
    request({7'd0, 32'h9000_0014});
    respond(1, G2);
    check("t5_allowin_at7", 71'(u_if.fs_allowin), 71'd0);
    check("t5_head_hold", u_if.fs_to_ds_bus, {7'd0, 32'h9000_0000, 32'hbbbb_0000});
    u_if.to_fs_valid     = 1'b1;
    u_if.preif_to_fs_bus = {7'd0, 32'h9000_0020};
    repeat (3) tick();
    check("t5_hold_stable", u_if.fs_to_ds_bus, {7'd0, 32'h9000_0000, 32'hbbbb_0000});
    u_if.ds_allowin = 1'b1;
    request({7'd0, 32'h9000_0020});
    respond(0, G1);
    repeat (12) tick();
    check("t5_drained", 71'(u_if.fs_to_ds_valid), 71'd0);

    // Reflush coincident with data_ok
    u_if.ds_allowin = 1'b0;
    request({1'b0, 1'b1, 5'd1, 32'h0000_0100});
    request({7'd0, 32'ha000_0000});
    u_if.fs_reflush = 1'b1;
    respond(0, GS);
    u_if.fs_reflush = 1'b0;
    check("t6_allowin", 71'(u_if.fs_allowin), 71'd1);
    check("t6_empty", 71'(u_if.fs_to_ds_valid), 71'd0);

    // Reflush in IDLE with an exception accept: entry survives the clear
    request({1'b0, 1'b1, 5'd1, 32'h0000_0100});
    u_if.fs_reflush = 1'b1;
    request({1'b1, 1'b1, 5'd3, 32'h0000_0200});
    u_if.fs_reflush = 1'b0;
    check("t7_entry", u_if.fs_to_ds_bus, {1'b1, 1'b1, 5'd3, 32'h0000_0200, 32'h0});
    tick();
    check("t7_hold", u_if.fs_to_ds_bus, {1'b1, 1'b1, 5'd3, 32'h0000_0200, 32'h0});
    u_if.ds_allowin = 1'b1;
    tick();
    check("t7_popped", 71'(u_if.fs_to_ds_valid), 71'd0);

    // Reflush in IDLE with a normal accept: the new target is fetched
    u_if.fs_reflush = 1'b1;
    request({7'd0, 32'hb000_0004});
    u_if.fs_reflush = 1'b0;
    check("t8_offset", 71'(u_if.inst_offset), 71'd12);
    respond(2, G3);
    check("t8_head", u_if.fs_to_ds_bus, {7'd0, 32'hb000_0004, 32'hbbbb_0001});
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
